uart_tx_io: RTL and testbench

- Memory-mapped UART transmitter on the processor IO page, alongside the LED, 7-segment and switch registers.
- Downstream of the CPU store path: the top-level IO decode delivers byte writes; the block buffers them in a small FIFO and serialises them 8N1 on txd.
- It also returns a status word that the top-level IO read mux places on mem_rdata.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_fifo.sv | 62 ++++++
 rtl/uart_tx_io.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_io.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the IO-page UART transmitter: FSM states, 8N1 frame
// constants and status-word bit positions used by the IO read decode.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int unsigned DATA_BITS = 8;
   localparam logic        START_LVL = 1'b0;
   localparam logic        STOP_LVL  = 1'b1;

   localparam int unsigned ST_EMPTY  = 8;
   localparam int unsigned ST_FULL   = 9;
   localparam int unsigned ST_BUSY   = 10;
   localparam int unsigned ST_OVF    = 11;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous circular-buffer FIFO. The head entry is always visible on dout.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module uart_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   // storage array; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // wrap-around pointers and occupancy count
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter for the processor IO page. Byte writes
// are queued in a FIFO and shifted out LSB first on txd; a status word and an
// empty interrupt are returned to the IO read mux.
module uart_tx_io
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned DIV        = CLK_FREQ / BAUD,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [7:0]  wr_data,
   input  logic        clr_ovf,
   output logic        txd,
   output logic [31:0] status,
   output logic        irq_empty
);

   localparam int unsigned BW = $clog2(DIV);
   localparam int unsigned IW = $clog2(DATA_BITS);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
   localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

   tx_state_t      state, state_d;
   logic [BW-1:0]  baud, baud_d;
   logic [IW-1:0]  bit_idx, bit_idx_d;
   logic [7:0]     shift, shift_d;
   logic           txd_d;
   logic           overflow, overflow_d;
   logic           pop;
   logic           drop;
   logic           baud_end;

   logic [7:0]     head;
   logic           fifo_full;
   logic           fifo_empty;
   logic [CW-1:0]  fifo_count;

   uart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_en),
      .pop   (pop),
      .din   (wr_data),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign baud_end = (baud == BAUD_LAST);

   // state register plus shifter, counters, txd and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         txd      <= STOP_LVL;
         overflow <= 1'b0;
      end else begin
         state    <= state_d;
         baud     <= baud_d;
         bit_idx  <= bit_idx_d;
         shift    <= shift_d;
         txd      <= txd_d;
         overflow <= overflow_d;
      end
   end

   // next-state: bit timing, shifting and FIFO pops at frame boundaries
   always_comb begin
      state_d   = state;
      baud_d    = baud;
      bit_idx_d = bit_idx;
      shift_d   = shift;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = DATA;
            end else begin
               baud_d = baud + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift[7:1]};
               if (bit_idx == BIT_LAST) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx + 1'b1;
               end
            end else begin
               baud_d = baud + 1'b1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               // chain straight into the next start bit so frames stay contiguous
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // output decode from the upcoming state so txd is a clean flop output
   always_comb begin
      case (state_d)
         START:   txd_d = START_LVL;
         DATA:    txd_d = shift_d[0];
         default: txd_d = STOP_LVL;
      endcase
   end

   // overflow: a dropped write sets it and takes priority over a clear
   always_comb begin
      drop       = wr_en & fifo_full & ~pop;
      overflow_d = drop | (overflow & ~clr_ovf);
   end

   // status word assembled purely from flops, so it moves only on clk edges
   always_comb begin
      status           = '0;
      status[7:0]      = 8'(fifo_count);
      status[ST_EMPTY] = fifo_empty;
      status[ST_FULL]  = fifo_full;
      status[ST_BUSY]  = (state != IDLE);
      status[ST_OVF]   = overflow;
   end

   assign irq_empty = fifo_empty & (state == IDLE);

endmodule

// File: tb/tb_uart_tx_io.sv
// Self-checking bench for uart_tx_io (DIV=10, FIFO_DEPTH=4). The reference
// model keeps each accepted byte with the edge its frame starts on and derives
// line level, FIFO occupancy and busy from frame arithmetic.
module tb_uart_tx_io;

   localparam int DIV   = 10;
   localparam int FRAME = 10 * DIV;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_data = 8'h00;
   logic        clr_ovf = 1'b0;
   logic        txd;
   logic [31:0] status;
   logic        irq_empty;

   int checks = 0;
   int fails  = 0;
   int t      = 0;        // index of the next clock edge

   int         q_s[$];    // edge on which each accepted byte's frame starts
   logic [7:0] q_b[$];    // the accepted bytes, in order
   int         last_end = 0;
   logic       m_ovf = 1'b0;

   always #5 clk = ~clk;

   uart_tx_io #(
      .CLK_FREQ   (1000),
      .BAUD       (100),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .clr_ovf   (clr_ovf),
      .txd       (txd),
      .status    (status),
      .irq_empty (irq_empty)
   );

   function automatic int m_count(input int tt);
      int n;
      n = 0;
      foreach (q_s[i]) if (q_s[i] > tt) n++;
      return n;
   endfunction

   function automatic int m_active(input int tt);
      foreach (q_s[i]) if (q_s[i] <= tt && tt < q_s[i] + FRAME) return i;
      return -1;
   endfunction

   function automatic logic m_pop_at(input int tt);
      foreach (q_s[i]) if (q_s[i] == tt) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic m_txd(input int tt);
      int k;
      int pos;
      logic [7:0] b;
      k = m_active(tt);
      if (k < 0) return 1'b1;
      pos = (tt - q_s[k]) / DIV;
      b = q_b[k];
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return b[pos-1];
   endfunction

   function automatic logic [31:0] m_status(input int tt);
      int c;
      logic [31:0] s;
      c = m_count(tt);
      s = '0;
      s[7:0] = 8'(c);
      s[8]   = (c == 0);
      s[9]   = (c == DEPTH);
      s[10]  = (m_active(tt) >= 0);
      s[11]  = m_ovf;
      return s;
   endfunction

   function automatic logic m_irq(input int tt);
      return (m_count(tt) == 0) && (m_active(tt) < 0);
   endfunction

   task automatic model_edge(input logic we, input logic [7:0] d,
                             input logic clr, input logic rst);
      int   cprev;
      int   s;
      logic drop;
      while (q_s.size() > 0 && q_s[0] + FRAME < t) begin
         void'(q_s.pop_front());
         void'(q_b.pop_front());
      end
      if (rst) begin
         q_s.delete();
         q_b.delete();
         last_end = 0;
         m_ovf    = 1'b0;
      end else begin
         cprev = m_count(t - 1);
         drop  = 1'b0;
         if (we) begin
            if (cprev < DEPTH || m_pop_at(t)) begin
               s = (t + 1 > last_end) ? t + 1 : last_end;
               q_s.push_back(s);
               q_b.push_back(d);
               last_end = s + FRAME;
            end else begin
               drop = 1'b1;
            end
         end
         if (drop) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s t=%0d observed %h expected %h", tag, t - 1, obs, exp);
      end
   endtask

   task automatic check_outputs();
      checks++;
      assert (txd === m_txd(t)) else begin
         fails++;
         $error("FAIL txd t=%0d observed %b expected %b", t, txd, m_txd(t));
      end
      checks++;
      assert (status === m_status(t)) else begin
         fails++;
         $error("FAIL status t=%0d observed %h expected %h", t, status, m_status(t));
      end
      checks++;
      assert (irq_empty === m_irq(t)) else begin
         fails++;
         $error("FAIL irq_empty t=%0d observed %b expected %b", t, irq_empty, m_irq(t));
      end
   endtask

   task automatic cycle(input logic we, input logic [7:0] d,
                        input logic clr, input logic rst);
      wr_en   = we;
      wr_data = d;
      clr_ovf = clr;
      reset   = rst;
      model_edge(we, d, clr, rst);
      @(posedge clk);
      @(negedge clk);
      wr_en   = 1'b0;
      clr_ovf = 1'b0;
      reset   = 1'b0;
      check_outputs();
      t++;
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] ob [6];
      ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      // reset state
      repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check("rst_status", status, 32'h0000_0100);
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_irq", 32'(irq_empty), 32'd1);
      repeat (2) idle();

      // single byte: start bit on the edge after the write, irq back at N+101
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      idle();
      check("a5_start_low", 32'(txd), 32'd0);
      repeat (99) idle();
      check("a5_irq_last_stop", 32'(irq_empty), 32'd0);
      idle();
      check("a5_irq_after", 32'(irq_empty), 32'd1);
      repeat (5) idle();

      // back-to-back frames on consecutive writes
      cycle(1'b1, 8'h55, 1'b0, 1'b0);
      cycle(1'b1, 8'h0F, 1'b0, 1'b0);
      repeat (150) idle();
      check("b2b_busy", 32'(status[10]), 32'd1);
      repeat (60) idle();

      // overflow: six writes while the first frame is in flight
      for (int i = 0; i < 6; i++) cycle(1'b1, ob[i], 1'b0, 1'b0);
      check("ovf_set", 32'(status[11]), 32'd1);
      check("ovf_count", 32'(status[7:0]), 32'd4);
      check("ovf_full", 32'(status[9]), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("ovf_clear", 32'(status[11]), 32'd0);

      // write into a full FIFO on the STOP->START pop edge
      for (int i = 0; i < 300 && !m_pop_at(t); i++) idle();
      cycle(1'b1, 8'h3C, 1'b0, 1'b0);
      check("popwr_count", 32'(status[7:0]), 32'd4);
      check("popwr_no_ovf", 32'(status[11]), 32'd0);
      repeat (520) idle();
      check("drain_irq", 32'(irq_empty), 32'd1);

      // reset during data bit 3 of 0xFF abandons the frame
      cycle(1'b1, 8'hFF, 1'b0, 1'b0);
      repeat (45) idle();
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      check("midrst_txd", 32'(txd), 32'd1);
      check("midrst_status", status, 32'h0000_0100);
      repeat (150) idle();
      check("midrst_quiet", 32'(irq_empty), 32'd1);

      // randomized traffic with occasional clears and resets
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 7) == 0), 8'($urandom),
               ($urandom_range(0, 39) == 0), ($urandom_range(0, 599) == 0));
      end
      repeat (700) idle();
      check("final_irq", 32'(irq_empty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
